// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Multiply is shift-add over a 2*WIDTH product held in hi/lo; divide is
// restoring over a WIDTH+1-bit partial remainder reusing the same hi/lo pair.
// Build option: define MULDIV_DIV_EN to compile the divider; without it,
// divide ops complete in two cycles with Result=0 and Illegal=1.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Illegal
);

   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           state_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] opnd_q;     // multiplicand magnitude, or divisor magnitude
   logic [WIDTH-1:0] hi_q;       // product high half, or partial remainder
   logic [WIDTH-1:0] lo_q;       // multiplier/product low half, or dividend/quotient
   logic [CntW-1:0]  cnt_q;
   logic             neg_a_q;
   logic             neg_b_q;

   logic             sign_a_in;
   logic             sign_b_in;
   logic             neg_a_in;
   logic             neg_b_in;
   logic             special_in;
   logic [WIDTH-1:0] mag_a_in;
   logic [WIDTH-1:0] mag_b_in;
   logic [WIDTH-1:0] spec_hi;
   logic [WIDTH-1:0] spec_lo;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]   fix_res;
   logic               fix_ill;

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
`endif

   // Decode operand signedness at issue, take magnitudes, and spot the fast-path divides
   always_comb begin
      sign_a_in  = 1'b0;
      sign_b_in  = 1'b0;
      special_in = 1'b0;
      spec_hi    = '0;
      spec_lo    = '0;
      if (funct3[2]) begin
         // DIV (100) and REM (110) are the signed divides
         sign_a_in = ~funct3[0];
         sign_b_in = ~funct3[0];
      end else begin
         sign_a_in = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
         sign_b_in = (funct3[1:0] == 2'b01);
      end
      neg_a_in = sign_a_in & SrcA[WIDTH-1];
      neg_b_in = sign_b_in & SrcB[WIDTH-1];
      mag_a_in = neg_a_in ? -SrcA : SrcA;
      mag_b_in = neg_b_in ? -SrcB : SrcB;
`ifdef MULDIV_DIV_EN
      // Fast paths preload quotient into lo and remainder into hi so FIX passes them through
      if (funct3[2] && (SrcB == '0)) begin
         special_in = 1'b1;
         spec_hi    = SrcA;
         spec_lo    = '1;
      end else if (funct3[2] && sign_a_in && (SrcA == MinNeg) && (SrcB == '1)) begin
         special_in = 1'b1;
         spec_hi    = '0;
         spec_lo    = SrcA;
      end
`else
      // Without the divider every divide op goes straight to FIX and is flagged there
      special_in = funct3[2];
`endif
   end

   assign mul_sum = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});

`ifdef MULDIV_DIV_EN
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};
`endif

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      if (op_q[2]) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Sign correction and result selection applied in FIX
   always_comb begin
      prod_fix = {hi_q, lo_q};
      if (neg_a_q ^ neg_b_q) begin
         prod_fix = -{hi_q, lo_q};
      end
      mul_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      fix_res = mul_res;
      fix_ill = 1'b0;
`ifdef MULDIV_DIV_EN
      quo_fix = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      rem_fix = neg_a_q ? -hi_q : hi_q;
      if (op_q[2]) begin
         fix_res = op_q[1] ? rem_fix : quo_fix;
      end
`else
      if (op_q[2]) begin
         fix_res = '0;
         fix_ill = 1'b1;
      end
`endif
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Result  <= '0;
         Illegal <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               Done <= 1'b0;
               if (Start) begin
                  op_q  <= funct3;
                  cnt_q <= '0;
                  Busy  <= 1'b1;
                  if (special_in) begin
                     state_q <= StFix;
                     opnd_q  <= '0;
                     neg_a_q <= 1'b0;
                     neg_b_q <= 1'b0;
                     hi_q    <= spec_hi;
                     lo_q    <= spec_lo;
                  end else begin
                     state_q <= StCalc;
                     neg_a_q <= neg_a_in;
                     neg_b_q <= neg_b_in;
                     hi_q    <= '0;
                     if (funct3[2]) begin
                        opnd_q <= mag_b_in;
                        lo_q   <= mag_a_in;
                     end else begin
                        opnd_q <= mag_a_in;
                        lo_q   <= mag_b_in;
                     end
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StCalc: begin
               hi_q  <= step_hi;
               lo_q  <= step_lo;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               state_q <= StDone;
               Busy    <= 1'b0;
               Done    <= 1'b1;
               Result  <= fix_res;
               Illegal <= fix_ill;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): vector table plus hand sequences for
// back-to-back issue, ignored Start while busy, and reset mid-operation.
// Expected results are queued at issue and checked when Done pulses.
// Cycle numbering: the cycle following clock edge k is cycle k+1.
module tb_muldiv_unit;

   localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          Start;
   logic [2:0]    funct3;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic          Busy;
   logic          Done;
   logic [W-1:0]  Result;
   logic          Illegal;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .funct3  (funct3),
      .SrcA    (SrcA),
      .SrcB    (SrcB),
      .Busy    (Busy),
      .Done    (Done),
      .Result  (Result),
      .Illegal (Illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;   // expected with the divider compiled in
   } vec_t;

   typedef struct {
      logic [W-1:0] r;
      logic         ill;
      int           cyc;
      int           busy;
      int           id;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!f[2]) return 34;
      if (!DivEn) return 2;
      if (b == 0) return 2;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Reference model from native 64-bit and int arithmetic: {Illegal, Result}
   function automatic logic [32:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      p  = {32'd0, a} * {32'd0, b};
      case (f)
         3'b000: return {1'b0, p[31:0]};
         3'b001: begin p = sa * sb; return {1'b0, p[63:32]}; end
         3'b010: begin p = sa * ub; return {1'b0, p[63:32]}; end
         3'b011: return {1'b0, p[63:32]};
         default: begin
            if (!DivEn) return {1'b1, 32'd0};
            if (b == 0) return (f[1]) ? {1'b0, a} : {1'b0, 32'hFFFF_FFFF};
            if (f == 3'b100) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a};
               return {1'b0, 32'(ia / ib)};
            end
            if (f == 3'b110) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 33'd0;
               return {1'b0, 32'(ia % ib)};
            end
            if (f == 3'b101) return {1'b0, a / b};
            return {1'b0, a % b};
         end
      endcase
   endfunction

   // Drive one request; caller is positioned away from the rising edge
   task automatic issue(input int id, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic ill);
      exp_t e;
      Start  = 1'b1;
      funct3 = f;
      SrcA   = a;
      SrcB   = b;
      @(posedge clk);
      #1;
      e.r    = r;
      e.ill  = ill;
      e.cyc  = cyc + lat(f, a, b) - 1;
      e.busy = lat(f, a, b) - 1;
      e.id   = id;
      sb.push_back(e);
      // Scramble inputs: the unit must have captured its operands already
      Start  = 1'b0;
      funct3 = 3'($urandom);
      SrcA   = $urandom;
      SrcB   = $urandom;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         chk("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Scoreboard: count Busy cycles and check each Done against the queue head
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (Busy) busy_cnt++;
         if (Done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("result#%0d", e.id), 64'(Result), 64'(e.r));
               chk($sformatf("illegal#%0d", e.id), 64'(Illegal), 64'(e.ill));
               chk($sformatf("done_cycle#%0d", e.id), 64'(cyc), 64'(e.cyc));
               chk($sformatf("busy_cycles#%0d", e.id), 64'(busy_cnt), 64'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [32:0]  m;
      logic [2:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         ill;
      int           dn;

      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[6]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF};
      vecs[7]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[8]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
      vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[11] = '{3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C};
      vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};
      vecs[13] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
      vecs[14] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[15] = '{3'b100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

      reset  = 1'b1;
      Start  = 1'b0;
      funct3 = 3'b000;
      SrcA   = '0;
      SrcB   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(Busy), 64'd0);
      chk("reset_done", 64'(Done), 64'd0);
      chk("reset_result", 64'(Result), 64'd0);
      chk("reset_illegal", 64'(Illegal), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         r   = vecs[i].r;
         ill = 1'b0;
         if (vecs[i].f[2] && !DivEn) begin
            r   = '0;
            ill = 1'b1;
         end
         @(negedge clk);
         issue(i, vecs[i].f, vecs[i].a, vecs[i].b, r, ill);
         wait_idle();
      end

      // Random operands against the native-arithmetic model
      for (int i = 0; i < 12; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 4 == 0) ? '0 : W'($urandom);
         if (i == 6) begin
            f = 3'b100;
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         m = model(f, a, b);
         @(negedge clk);
         issue(50 + i, f, a, b, m[31:0], m[32]);
         wait_idle();
      end

      // Back-to-back: second Start lands in the Done cycle of the first
      @(negedge clk);
      issue(100, 3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0);
      for (int i = 0; i < 60 && !Done; i++) @(negedge clk);
      if (Done) begin
         issue(101, 3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
      end else begin
         chk("b2b_first_done_seen", 64'd0, 64'd1);
      end
      wait_idle();

      // Start pulsed mid-CALC must be ignored
      @(negedge clk);
      issue(102, 3'b000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0);
      repeat (5) @(negedge clk);
      Start  = 1'b1;
      funct3 = 3'b001;
      SrcA   = 32'hDEAD_BEEF;
      SrcB   = 32'h0000_0003;
      @(negedge clk);
      Start  = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      // Reset mid-operation: no Done, outputs back to reset values
      Start  = 1'b1;
      funct3 = 3'b000;
      SrcA   = 32'h0000_0005;
      SrcB   = 32'h0000_0006;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", 64'(Busy), 64'd0);
      chk("abort_done", 64'(Done), 64'd0);
      chk("abort_result", 64'(Result), 64'd0);
      chk("abort_illegal", 64'(Illegal), 64'd0);
      busy_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'd0);
      chk("abort_result_held", 64'(Result), 64'd0);

      // Recovery after abort
      @(negedge clk);
      issue(103, 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
      wait_idle();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
